// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: accept in IDLE, drive the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [ALUopSize-1:0] req0_op,
  input  logic [ALUopSize-1:0] req1_op,
  input  logic [DataSize-1:0]  req0_a,
  input  logic [DataSize-1:0]  req0_b,
  input  logic [DataSize-1:0]  req1_a,
  input  logic [DataSize-1:0]  req1_b,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic [DataSize-1:0]  alu_src1,
  output logic [DataSize-1:0]  alu_src2,
  output logic [ALUopSize-1:0] alu_type,
  input  logic [DataSize-1:0]  alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [DataSize-1:0]  rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 busy,
  output logic [15:0]          op_count
);

  // state | meaning
  // IDLE  | waiting for a request, ready may be asserted
  // EXEC  | captured operands drive the ALU for one cycle
  // RESP  | registered result presented until rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ALUopSize-1:0]   op_q;
  logic [DataSize-1:0]    a_q;
  logic [DataSize-1:0]    b_q;
  logic                   id_q;
  logic                   last_q;
  logic                   grant0;
  logic                   grant1;
  logic                   accept;
  logic                   complete;

  // last_q holds the index served most recently; reset to 1 so req0 wins first contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept   = grant0 || grant1;
  assign complete = (state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    rsp_id     = id_q;
    alu_type   = ALUopSize'(8);
    alu_src1   = '0;
    alu_src2   = '0;
    if (state == EXEC) begin
      alu_type = op_q;
      alu_src1 = a_q;
      alu_src2 = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      op_count     <= 16'd0;
    end else begin
      if (accept) begin
        op_q <= grant1 ? req1_op : req0_op;
        a_q  <= grant1 ? req1_a  : req0_a;
        b_q  <= grant1 ? req1_b  : req0_b;
        id_q <= grant1;
      end
      if (state == EXEC) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
      end
      if (complete) begin
        last_q <= id_q;
        if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter DataSize, default 32, sets the operand and result width.
- REQ-002: Parameter ALUopSize, default 4, sets the operation code width.
- REQ-003: Port clk, input, 1 bit, rising-edge clock.
- REQ-004: Port rst, input, 1 bit, reset; rst SHALL be synchronous and active-low.
- REQ-005: Ports req0_valid and req1_valid, input, 1 bit each, requester n presents an operation.
- REQ-006: Ports req0_op and req1_op, input, ALUopSize bits each, ALU operation code.
- REQ-007: Ports req0_a, req0_b, req1_a and req1_b, input, DataSize bits each, operands.
- REQ-008: Ports req0_ready and req1_ready, output, 1 bit each, arbiter accepts requester n this cycle.
- REQ-009: Ports alu_src1 and alu_src2, output, DataSize bits each, operands to the shared ALU.
- REQ-010: Port alu_type, output, ALUopSize bits, operation to the shared ALU.
- REQ-011: Ports alu_result (input, DataSize bits), alu_zero and alu_overflow (input, 1 bit each), combinational ALU outputs.
- REQ-012: Ports rsp_valid (output, 1 bit) and rsp_ready (input, 1 bit), response handshake.
- REQ-013: Port rsp_id, output, 1 bit, index of the requester that owns the response.
- REQ-014: Port rsp_result, output, DataSize bits, registered ALU result.
- REQ-015: Ports rsp_zero and rsp_overflow, output, 1 bit each, registered ALU flags.
- REQ-016: Port busy, output, 1 bit, high when the FSM is not in IDLE.
- REQ-017: Port op_count, output, 16 bits, number of completed operations, saturating at 16'hFFFF.

Function
- REQ-018: The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
- REQ-019: In IDLE with at least one valid request, the arbiter SHALL assert ready to exactly one requester, chosen as follows.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester not granted last wins (round-robin pointer).
- REQ-020: A ready signal SHALL be combinational, asserted only in IDLE, and never asserted to a requester whose valid is low.
- REQ-021: On a valid&ready edge, the FSM SHALL capture op, a, b and the requester index into internal registers and move to EXEC.
- REQ-022: In EXEC, the ALU drive SHALL be as follows.
  - alu_src1 and alu_src2 = captured a and b.
  - alu_type = captured op.
  - Any op code, including 8..15, is passed through unmodified.
- REQ-023: Outside EXEC, the ALU drive SHALL be as follows.
  - alu_type = 4'd8 (undefined op).
  - alu_src1 and alu_src2 = 0.
- REQ-024: At the end of the single EXEC cycle, the FSM SHALL register alu_result, alu_zero and alu_overflow into rsp_result, rsp_zero and rsp_overflow, then move to RESP.
- REQ-025: In RESP, the response side SHALL behave as follows.
  - rsp_valid = 1; rsp_id = captured index.
  - rsp_* are held stable until rsp_ready = 1.
- REQ-026: On a rsp_valid&rsp_ready edge, the block SHALL complete the operation as follows.
  - FSM goes to IDLE.
  - Round-robin pointer is updated to the served requester.
  - op_count increments unless it is at 16'hFFFF.
- REQ-027: No request SHALL be accepted in EXEC or RESP; the minimum latency from accept to rsp_valid is 2 cycles and the minimum issue interval is 3 cycles.
- REQ-028: A requester that drops valid before being granted SHALL NOT be served; the arbiter SHALL NOT require valid to stay high after the accept edge.
- REQ-029: rsp_zero and rsp_overflow SHALL be passed through from the ALU without interpretation, whatever the op.

Reset
- REQ-030: When rst = 0 at a rising clock edge, the block SHALL reset as follows.
  - FSM goes to IDLE.
  - rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, busy and op_count = 0.
  - Round-robin pointer favours req0.
- REQ-031: Reset asserted in EXEC or RESP SHALL discard the in-flight operation: no response is issued and op_count is not incremented.
- REQ-032: While rst = 0, req0_ready and req1_ready SHALL be 0.

Verification
- REQ-033: Single add: req0 op=0, a=5, b=7 with rsp_ready = 1 -> req0_ready in the accept cycle; rsp_valid exactly 2 cycles later with rsp_id = 0, rsp_result = 12; op_count = 1.
- REQ-034: Contention: both valid continuously from reset -> grants in the order req0, req1, req0, req1, with 3-cycle spacing.
- REQ-035: Backpressure: rsp_ready held at 0 for 5 cycles during a SUB of 3 - 5 -> rsp_valid high and rsp_result = 32'hFFFFFFFE stable for 5 cycles; no new accept until the handshake.
- REQ-036: Overflow passthrough: ADD of 32'h7FFFFFFF and 1 -> rsp_result = 32'h80000000 and rsp_overflow = 1.
- REQ-037: Reset mid-op: rst = 0 during EXEC -> no rsp_valid follows; op_count = 0; next grant goes to req0.
- REQ-038: Saturation: op_count forced to 16'hFFFF, then one more operation completed -> op_count stays 16'hFFFF.
